voice_allocator: RTL

Polyphonic voice allocator that sequences the synth's oscillator bank. It accepts note-on/note-off events from the processor-side key/amp/note registers and assigns them to NUM_VOICES oscillator slots, stealing the oldest slot when all are busy. Per-voice note index, amplitude, gate and a one-cycle load strobe drive each NCO's note-lookup ROM and its loadF/loadA/key_on inputs. It sits between the SoC PIO exports and the NCO array, on the same clock as the audio path.

---
 rtl/synth_pkg.sv | 20 ++
 rtl/voice_allocator_if.sv | 29 ++
 rtl/voice_slot.sv | 39 +++
 rtl/voice_allocator.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared widths, allocator state encoding and note event type
package synth_pkg;

  localparam int DEF_NOTE_W = 7;
  localparam int DEF_AMP_W  = 16;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    COMMIT
  } alloc_state_t;

  // Same layout the SoC bridge packs from the key/amp/note registers.
  typedef struct packed {
    logic                  on;
    logic [DEF_NOTE_W-1:0] note;
    logic [DEF_AMP_W-1:0]  amp;
  } note_event_t;

endpackage

// File: rtl/voice_allocator_if.sv
// rtl/voice_allocator_if.sv - event handshake and per-voice oscillator outputs
interface voice_allocator_if import synth_pkg::*; #(
  parameter int NUM_VOICES = 4,
  parameter int NOTE_W     = DEF_NOTE_W,
  parameter int AMP_W      = DEF_AMP_W
) ();

  logic                         ev_valid;
  logic                         ev_ready;
  logic                         ev_on;
  logic [NOTE_W-1:0]            ev_note;
  logic [AMP_W-1:0]             ev_amp;
  logic [NUM_VOICES*NOTE_W-1:0] voice_note;
  logic [NUM_VOICES*AMP_W-1:0]  voice_amp;
  logic [NUM_VOICES-1:0]        voice_gate;
  logic [NUM_VOICES-1:0]        voice_load;
  logic                         steal;

  modport master (
    output ev_valid, ev_on, ev_note, ev_amp,
    input  ev_ready, voice_note, voice_amp, voice_gate, voice_load, steal
  );

  modport slave (
    input  ev_valid, ev_on, ev_note, ev_amp,
    output ev_ready, voice_note, voice_amp, voice_gate, voice_load, steal
  );

endinterface

// File: rtl/voice_slot.sv
// rtl/voice_slot.sv - one oscillator slot: note/amp/gate registers and saturating age
module voice_slot import synth_pkg::*; #(
  parameter int NOTE_W = DEF_NOTE_W,
  parameter int AMP_W  = DEF_AMP_W,
  parameter int AGE_W  = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              wr,
  input  logic              gate_clr,
  input  logic              age_inc,
  input  logic [NOTE_W-1:0] wr_note,
  input  logic [AMP_W-1:0]  wr_amp,
  output logic [NOTE_W-1:0] note,
  output logic [AMP_W-1:0]  amp,
  output logic              gate,
  output logic [AGE_W-1:0]  age
);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      note <= '0;
      amp  <= '0;
      gate <= 1'b0;
      age  <= '0;
    end else if (wr) begin
      note <= wr_note;
      amp  <= wr_amp;
      gate <= 1'b1;
      age  <= '0;
    end else begin
      if (gate_clr)
        gate <= 1'b0;
      if (age_inc && (age != '1))
        age <= age + 1'b1;
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - polyphonic allocator: sequential scan of slots, then one commit
module voice_allocator import synth_pkg::*; #(
  parameter int NUM_VOICES = 4,
  parameter int NOTE_W     = DEF_NOTE_W,
  parameter int AMP_W      = DEF_AMP_W,
  parameter int AGE_W      = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  voice_allocator_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  alloc_state_t state, state_n;

  logic              on_q;
  logic [NOTE_W-1:0] note_q;
  logic [AMP_W-1:0]  amp_q;
  logic [IDX_W-1:0]  scan_idx, match_idx, free_idx, oldest_idx, target;
  logic              match_found, free_found;
  logic [AGE_W-1:0]  oldest_age;

  logic [NOTE_W-1:0] slot_note [NUM_VOICES];
  logic [AMP_W-1:0]  slot_amp  [NUM_VOICES];
  logic [AGE_W-1:0]  slot_age  [NUM_VOICES];
  logic [NUM_VOICES-1:0] slot_gate, wr, gate_clr, age_inc, load_q;
  logic steal_n, steal_q, accept;

  assign bus.ev_ready = (state == IDLE) && !Reset;
  assign accept       = bus.ev_valid && bus.ev_ready;

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_slot
    voice_slot #(.NOTE_W(NOTE_W), .AMP_W(AMP_W), .AGE_W(AGE_W)) u_slot (
      .Clk      (Clk),
      .Reset    (Reset),
      .wr       (wr[v]),
      .gate_clr (gate_clr[v]),
      .age_inc  (age_inc[v]),
      .wr_note  (note_q),
      .wr_amp   (amp_q),
      .note     (slot_note[v]),
      .amp      (slot_amp[v]),
      .gate     (slot_gate[v]),
      .age      (slot_age[v])
    );
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    wr       = '0;
    gate_clr = '0;
    age_inc  = '0;
    steal_n  = 1'b0;
    target   = match_found ? match_idx : (free_found ? free_idx : oldest_idx);
    case (state)
      IDLE:   if (accept) state_n = SCAN;
      SCAN:   if (scan_idx == LAST_IDX) state_n = COMMIT;
      COMMIT: begin
        state_n = IDLE;
        if (on_q) begin
          wr[target] = 1'b1;
          age_inc    = ~wr;
          steal_n    = !match_found && !free_found;
        end else if (match_found) begin
          gate_clr[match_idx] = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Trackers see one slot per SCAN cycle; strict '>' keeps the lowest index on age ties.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      on_q        <= 1'b0;
      note_q      <= '0;
      amp_q       <= '0;
      scan_idx    <= '0;
      match_found <= 1'b0;
      match_idx   <= '0;
      free_found  <= 1'b0;
      free_idx    <= '0;
      oldest_age  <= '0;
      oldest_idx  <= '0;
    end else if (accept) begin
      on_q        <= bus.ev_on;
      note_q      <= bus.ev_note;
      amp_q       <= bus.ev_amp;
      scan_idx    <= '0;
      match_found <= 1'b0;
      match_idx   <= '0;
      free_found  <= 1'b0;
      free_idx    <= '0;
      oldest_age  <= '0;
      oldest_idx  <= '0;
    end else if (state == SCAN) begin
      scan_idx <= scan_idx + 1'b1;
      if (!match_found && slot_gate[scan_idx] && (slot_note[scan_idx] == note_q)) begin
        match_found <= 1'b1;
        match_idx   <= scan_idx;
      end
      if (!free_found && !slot_gate[scan_idx]) begin
        free_found <= 1'b1;
        free_idx   <= scan_idx;
      end
      if (slot_age[scan_idx] > oldest_age) begin
        oldest_age <= slot_age[scan_idx];
        oldest_idx <= scan_idx;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      load_q  <= '0;
      steal_q <= 1'b0;
    end else begin
      load_q  <= wr;
      steal_q <= steal_n;
    end
  end

  always_comb begin
    bus.voice_note = '0;
    bus.voice_amp  = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      bus.voice_note[v*NOTE_W +: NOTE_W] = slot_note[v];
      bus.voice_amp[v*AMP_W +: AMP_W]    = slot_amp[v];
    end
  end

  assign bus.voice_gate = slot_gate;
  assign bus.voice_load = load_q;
  assign bus.steal      = steal_q;

endmodule
